// File: rtl/ecgai_b2_pkg.sv
// rtl/ecgai_b2_pkg.sv - shared block-2 constants, weight-set type and bank FSM encoding
package ecgai_b2_pkg;

    localparam int N_CH    = 16;
    localparam int N_W     = 8;
    localparam int W_BITS  = 7;
    localparam int WS_BITS = N_W * W_BITS;
    localparam int CH_BITS = $clog2(N_CH);

    typedef logic [WS_BITS-1:0] weight_set_t;

    typedef enum logic [1:0] {
        ST_LOAD      = 2'd0,
        ST_DONE_WAIT = 2'd1,
        ST_READY     = 2'd2
    } bank_state_t;

    // Bit j flags weight slot [j*W_BITS +: W_BITS] as nonzero, so bit N_W-1 maps to w_0.
    function automatic logic [N_W-1:0] nonzero_mask(input weight_set_t ws);
        logic [N_W-1:0] m;
        m = '0;
        for (int j = 0; j < N_W; j++) begin
            m[j] = |ws[j*W_BITS +: W_BITS];
        end
        return m;
    endfunction

endpackage

// File: rtl/weight_bank_b2_if.sv
// rtl/weight_bank_b2_if.sv - PE-side read port of the block-2 weight bank; rd_mask exists only with WB_ZERO_MASK_EN
interface weight_bank_b2_if;
    import ecgai_b2_pkg::*;

    logic               rd_en;
    logic [CH_BITS-1:0] rd_ch;
    logic               rd_valid;
    weight_set_t        rd_weights;
`ifdef WB_ZERO_MASK_EN
    logic [N_W-1:0]     rd_mask;

    modport master (output rd_en, rd_ch, input rd_valid, rd_weights, rd_mask);
    modport slave  (input rd_en, rd_ch, output rd_valid, rd_weights, rd_mask);
`else
    modport master (output rd_en, rd_ch, input rd_valid, rd_weights);
    modport slave  (input rd_en, rd_ch, output rd_valid, rd_weights);
`endif
endinterface

// File: rtl/onehot_rise_detect.sv
// rtl/onehot_rise_detect.sv - rising-edge detector on the loader thermometer with one-hot index decode
module onehot_rise_detect #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [N-1:0]  nwv,
    output logic [N-1:0]  rise,
    output logic [IW-1:0] idx,
    output logic          one_hot,
    output logic          multi
);

    logic [N-1:0] nwv_q;

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            nwv_q <= '0;
        end else begin
            nwv_q <= nwv;
        end
    end

    assign rise    = nwv & ~nwv_q;
    assign one_hot = $onehot(rise);
    assign multi   = (rise != '0) && !$onehot(rise);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (rise[i]) idx = i[IW-1:0];
        end
    end

endmodule

// File: rtl/weight_bank_b2.sv
// rtl/weight_bank_b2.sv - block-2 weight register bank: captures loader channels, serves 1-cycle reads.
// Optional macro WB_ZERO_MASK_EN adds the registered nonzero-weight mask on the read port.
module weight_bank_b2
    import ecgai_b2_pkg::*;
#(
    parameter int N_CH   = 16,
    parameter int N_W    = 8,
    parameter int W_BITS = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_W*W_BITS-1:0]   w_in,
    input  logic [N_CH-1:0]         new_weight_val,
    input  logic                    weight_trans_done,
    input  logic                    clear,
    weight_bank_b2_if.slave         rd,
    output logic                    weights_ready,
    output logic                    load_err
);

    localparam int IW = $clog2(N_CH);

    logic [N_W*W_BITS-1:0] bank [N_CH];
    logic [N_CH-1:0]       valid_map;
    logic [N_CH-1:0]       vm_next;
    bank_state_t           state;
    logic                  done_q;

    logic [N_CH-1:0] rise;
    logic [IW-1:0]   idx;
    logic            one_hot;
    logic            multi;
    logic            capture;
    logic            bad_rise;
    logic            done_rise;
    logic            rd_take;

    onehot_rise_detect #(.N(N_CH), .IW(IW)) u_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .nwv     (new_weight_val),
        .rise    (rise),
        .idx     (idx),
        .one_hot (one_hot),
        .multi   (multi)
    );

    // A rise is only captured into an empty slot while loading; everything else is a protocol fault.
    always_comb begin
        vm_next = valid_map;
        capture = 1'b0;
        if (state == ST_LOAD && one_hot && !valid_map[idx]) begin
            capture      = 1'b1;
            vm_next[idx] = 1'b1;
        end
    end

    assign bad_rise  = multi || (one_hot && valid_map[idx]) || ((rise != '0) && state != ST_LOAD);
    assign done_rise = weight_trans_done && !done_q && state == ST_LOAD;
    assign rd_take   = (state == ST_READY) && rd.rd_en;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state         <= ST_LOAD;
            valid_map     <= '0;
            done_q        <= 1'b0;
            load_err      <= 1'b0;
            weights_ready <= 1'b0;
            rd.rd_valid   <= 1'b0;
            rd.rd_weights <= '0;
`ifdef WB_ZERO_MASK_EN
            rd.rd_mask    <= '0;
`endif
            for (int k = 0; k < N_CH; k++) begin
                bank[k] <= '0;
            end
        end else begin
            done_q <= weight_trans_done;
            if (clear) begin
                state         <= ST_LOAD;
                valid_map     <= '0;
                load_err      <= 1'b0;
                weights_ready <= 1'b0;
                rd.rd_valid   <= 1'b0;
            end else begin
                if (capture) bank[idx] <= w_in;
                valid_map <= vm_next;
                if (bad_rise || done_rise) load_err <= 1'b1;
                weights_ready <= (state == ST_READY);

                case (state)
                    ST_LOAD:      if (&vm_next) state <= weight_trans_done ? ST_READY : ST_DONE_WAIT;
                    ST_DONE_WAIT: if (weight_trans_done) state <= ST_READY;
                    default:      state <= state;
                endcase

                rd.rd_valid <= rd_take;
                if (rd_take) begin
                    rd.rd_weights <= bank[rd.rd_ch];
`ifdef WB_ZERO_MASK_EN
                    rd.rd_mask    <= nonzero_mask(bank[rd.rd_ch]);
`endif
                end
            end
        end
    end

endmodule

// File: doc/weight_bank_b2.md
# weight_bank_b2

Block-2 weight register bank, directly downstream of the block-2 ROM weight loader. Captures the 16 output-channel weight sets (8 × 7-bit each) that the loader streams out on w_0..w_7 / new_weight_val, stores them locally, and serves any channel's 8 weights to the block-2 PE array through a one-cycle-latency read port. Raises `weights_ready` once all 16 channels and the loader's done flag are seen.

## Interface
Parameters:
- `N_CH`, 16: number of output channels, and the width of `new_weight_val`.
- `N_W`, 8: weights per channel.
- `W_BITS`, 7: weight width, two's complement.

Ports:
- `clk`  in  1  the single clock for the block.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-high (the port keeps the codebase name `rst_n`, but rst_n=1 resets).
- `w_in`  in  56  loader weights {w_0..w_7}, with w_0 in [55:49].
- `new_weight_val`  in  16  loader thermometer; bit k rising means channel k's weights are on `w_in`.
- `weight_trans_done`  in  1  loader done level.
- `clear`  in  1  one-cycle pulse that empties the bank and returns it to LOAD.
- `rd_en`  in  1  read request.
- `rd_ch`  in  4  channel to read.
- `rd_valid`  out  1  read data valid.
- `rd_weights`  out  56  channel weights, same packing as `w_in`.
- `weights_ready`  out  1  bank complete.
- `load_err`  out  1  sticky protocol error.
- `rd_mask`  out  8  nonzero-weight mask; present only with the macro defined.

## Operation
- Storage: 16 × 56-bit register array `bank`, plus a 16-bit `valid_map`. The previous `new_weight_val` is registered as `nwv_q`.
- Capture: `rise = new_weight_val & ~nwv_q`.
  - Exactly one bit k set in LOAD: `bank[k] <= w_in` and `valid_map[k] <= 1`.
  - Capture happens in the same cycle the bit first appears. `w_in` is guaranteed stable in that cycle only.
- FSM states:
  - LOAD to DONE_WAIT when `valid_map` becomes all-ones.
  - DONE_WAIT to READY when `weight_trans_done` = 1. If it is already 1, the transition happens in the same cycle `valid_map` completes.
  - Any state to LOAD on `clear`.
- `load_err` is set, and stays set until reset or `clear`, on any of:
  - more than one bit in `rise` in one cycle (no capture occurs that cycle);
  - `rise` hits a channel already in `valid_map` (the existing entry is kept);
  - `rise` nonzero in DONE_WAIT or READY (ignored);
  - `weight_trans_done` rising while in LOAD.
- Read port:
  - Accepted only in READY: `rd_valid <= 1` and `rd_weights <= bank[rd_ch]` on the next edge.
  - Outside READY, `rd_en` is ignored and `rd_valid <= 0`.
  - No backpressure; one read per cycle is sustained.
- `clear`:
  - Zeroes `valid_map`, `load_err`, `rd_valid` and `nwv_q`. The bank contents are left as-is.
  - `clear` wins over a simultaneous capture or read.
- Values are passed through unmodified; no arithmetic on weights.

## Timing
- Reset values:
  - `rd_valid` = 0, `rd_weights` = 0, `weights_ready` = 0, `load_err` = 0, `rd_mask` = 0.
  - FSM = LOAD, `valid_map` = 0, `nwv_q` = 0, all `bank` entries = 0.
- Capture latency: `valid_map[k]` is visible 1 cycle after its `rise`.
- `weights_ready` is registered and asserts 1 cycle after the FSM enters READY.
- Read latency: exactly 1 cycle from `rd_en` to `rd_valid`/`rd_weights`.
- `rd_weights` holds its last value while `rd_valid` = 0.
- Reset asserted mid-load or mid-read: all outputs return to their reset values on that edge; the bank must be reloaded.

## Configuration
- `WB_ZERO_MASK_EN` defined:
  - `rd_mask` port exists.
  - With each read, `rd_mask[i]` = 1 when weight i of the returned channel is nonzero (bit 7 ↔ w_0).
  - It is registered alongside `rd_weights` with the same 1-cycle latency, letting PEs skip zero multiplies.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `ecgai_b2_pkg`:
  - `N_CH`, `N_W`, `W_BITS` constants;
  - a `weight_set_t` 56-bit packed type;
  - FSM state encoding {LOAD, DONE_WAIT, READY}.
- One sub-module, `onehot_rise_detect`: registers `new_weight_val` and outputs `rise`, a 4-bit index, `one_hot` and `multi` flags.

## Test plan
- Nominal load: loader streams channels 0..15 with distinct patterns (channel k, weight i = k·8+i), then `weight_trans_done` → `weights_ready` = 1; reads of ch 0, 7, 15 return the exact patterns one cycle after `rd_en`.
- Back-to-back reads: reads of ch 3, 4, 5 on consecutive cycles → three consecutive `rd_valid` cycles with matching data, no bubbles.
- Protocol error: bits 2 and 3 of `new_weight_val` rise in the same cycle → `load_err` = 1, neither `valid_map[2]` nor `valid_map[3]` set, `weights_ready` stays 0.
- Early done: `weight_trans_done` rises after 10 channels → `load_err` = 1; FSM stays in LOAD until channel 15, then goes straight to READY.
- `clear` mid-read in READY, coinciding with `rd_en` → `rd_valid` = 0 next cycle, `weights_ready` = 0, FSM in LOAD; reload of all-zero weights then succeeds.
- With `WB_ZERO_MASK_EN`: channel weights {0, 5, 0, −1, 0, 0, 63, 0} → `rd_mask` = 8'b01010010.
